// File: rtl/line_buf_ctrl_if.sv
// Pixel stream, line-RAM and output bundle for line_buf_ctrl.
// slave = the controller's view; master = the view of its environment.
interface line_buf_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned ROW_WIDTH  = 9
);
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_sof;

  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_cur;
  logic [DATA_WIDTH-1:0] out_above;
  logic                  out_above_valid;
  logic [ADDR_WIDTH-1:0] out_col;
  logic [ROW_WIDTH-1:0]  out_row;
  logic                  out_eol;
  logic                  out_eof;
  logic                  sync_err;

  modport slave (
    input  in_valid, in_data, in_sof, mem_rdata,
    output mem_waddr, mem_wdata, mem_wr_en, mem_raddr, mem_rd_en,
    output out_valid, out_cur, out_above, out_above_valid,
    output out_col, out_row, out_eol, out_eof, sync_err
  );

  modport master (
    output in_valid, in_data, in_sof, mem_rdata,
    input  mem_waddr, mem_wdata, mem_wr_en, mem_raddr, mem_rd_en,
    input  out_valid, out_cur, out_above, out_above_valid,
    input  out_col, out_row, out_eol, out_eof, sync_err
  );
endinterface

// File: rtl/line_buf_ctrl.sv
// Single-line delay buffer sequencer: pairs each pixel with the one above it.
// Optional LBC_BORDER_REPLICATE_EN: row 0 reports out_above = out_cur instead of 0.
module line_buf_ctrl #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned LINE_WIDTH   = 640,
  parameter int unsigned FRAME_HEIGHT = 480,
  parameter int unsigned ROW_WIDTH    = 9
) (
  input logic            clk,
  input logic            rst_n,
  line_buf_ctrl_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(LINE_WIDTH - 1);
  localparam logic [ROW_WIDTH-1:0]  LAST_ROW = ROW_WIDTH'(FRAME_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_FIRST, S_LINES} state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_col, w_col;
  logic [ROW_WIDTH-1:0]  r_row, w_row;
  logic                  w_accept, w_restart, w_sync_err;
  logic                  w_last_col, w_last_row;

  logic                  r_out_valid, r_out_above_valid, r_out_eol, r_out_eof, r_sync_err;
  logic [DATA_WIDTH-1:0] r_out_cur;
  logic [ADDR_WIDTH-1:0] r_out_col;
  logic [ROW_WIDTH-1:0]  r_out_row;

  // A sof pixel always restarts at (0,0); outside IDLE it is also a sync error.
  assign w_restart  = bus.in_valid & bus.in_sof;
  assign w_accept   = rst_n & bus.in_valid & ((r_state != S_IDLE) | bus.in_sof);
  assign w_sync_err = rst_n & w_restart & (r_state != S_IDLE);
  assign w_col      = w_restart ? '0 : r_col;
  assign w_row      = w_restart ? '0 : r_row;
  assign w_last_col = (w_col == LAST_COL);
  assign w_last_row = (w_row == LAST_ROW);

  // RAM drive; the RAM's read-before-write gives the previous row's pixel.
  assign bus.mem_waddr = w_col;
  assign bus.mem_raddr = w_col;
  assign bus.mem_wdata = bus.in_data;
  assign bus.mem_wr_en = w_accept;
  assign bus.mem_rd_en = w_accept & ~w_restart & (r_state == S_LINES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) begin
      if (w_last_col && w_last_row) w_state_nxt = S_IDLE;
      else if (w_last_col)          w_state_nxt = S_LINES;
      else if (w_row == '0)         w_state_nxt = S_FIRST;
      else                          w_state_nxt = S_LINES;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : w_row + ROW_WIDTH'(1);
      end else begin
        r_col <= w_col + ADDR_WIDTH'(1);
        r_row <= w_row;
      end
    end
  end

  // Output stage: one cycle behind acceptance, aligned with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid       <= 1'b0;
      r_out_cur         <= '0;
      r_out_above_valid <= 1'b0;
      r_out_col         <= '0;
      r_out_row         <= '0;
      r_out_eol         <= 1'b0;
      r_out_eof         <= 1'b0;
      r_sync_err        <= 1'b0;
    end else begin
      r_out_valid <= w_accept;
      r_sync_err  <= w_sync_err;
      if (w_accept) begin
        r_out_cur         <= bus.in_data;
        r_out_above_valid <= (w_row != '0);
        r_out_col         <= w_col;
        r_out_row         <= w_row;
        r_out_eol         <= w_last_col;
        r_out_eof         <= w_last_col & w_last_row;
      end
    end
  end

  assign bus.out_valid       = r_out_valid;
  assign bus.out_cur         = r_out_cur;
  assign bus.out_above_valid = r_out_above_valid;
  assign bus.out_col         = r_out_col;
  assign bus.out_row         = r_out_row;
  assign bus.out_eol         = r_out_eol;
  assign bus.out_eof         = r_out_eof;
  assign bus.sync_err        = r_sync_err;

`ifdef LBC_BORDER_REPLICATE_EN
  assign bus.out_above = r_out_above_valid ? bus.mem_rdata : r_out_cur;
`else
  assign bus.out_above = r_out_above_valid ? bus.mem_rdata : '0;
`endif

endmodule

// File: doc/line_buf_ctrl.md
Name: line_buf_ctrl

Overview:
Sequences the dual-port pixel line RAM (`memory`) as a single-line delay buffer for the streaming image pipeline. Each accepted pixel is written at its column address. In the same cycle, the pixel stored at that address for the previous row is read back, so downstream 2-row kernels receive the current pixel and the pixel directly above it, column-aligned. The block tracks column, row and frame position, and flags end-of-line, end-of-frame and sync errors.

Parameters:
DATA_WIDTH, 8, pixel width in bits; matches the RAM DATA_WIDTH.
ADDR_WIDTH, 10, RAM address width; 2**ADDR_WIDTH >= LINE_WIDTH.
LINE_WIDTH, 640, pixels per row, >= 2.
FRAME_HEIGHT, 480, rows per frame, >= 2.
ROW_WIDTH, 9, row counter width; 2**ROW_WIDTH >= FRAME_HEIGHT.

Ports:
clk  in  1  single clock; drives this block and both RAM clocks
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  pixel qualifier, one pixel per cycle when high
in_data  in  DATA_WIDTH  pixel
in_sof  in  1  start of frame, qualified by in_valid; marks pixel (row 0, col 0)
mem_waddr  out  ADDR_WIDTH  RAM write address
mem_wdata  out  DATA_WIDTH  RAM write data
mem_wr_en  out  1  RAM write enable
mem_raddr  out  ADDR_WIDTH  RAM read address
mem_rd_en  out  1  RAM read enable
mem_rdata  in  DATA_WIDTH  RAM registered read data, 1-cycle latency
out_valid  out  1  output pixel qualifier
out_cur  out  DATA_WIDTH  current pixel
out_above  out  DATA_WIDTH  pixel at the same column, previous row
out_above_valid  out  1  high when out_above is real data (row >= 1)
out_col  out  ADDR_WIDTH  column of the output pixel
out_row  out  ROW_WIDTH  row of the output pixel
out_eol  out  1  output pixel is the last in its row
out_eof  out  1  output pixel is the last in the frame
sync_err  out  1  one-cycle pulse on a frame sync violation

Behaviour:
- Reset: all registered outputs are 0, state is IDLE, and the col/row counters are 0. mem_wr_en and mem_rd_en are 0 while rst_n is low.
- States:
  - IDLE: wait for in_valid & in_sof. Valid pixels without sof are dropped, with no RAM access and no output.
  - FIRST: row 0. Write only; no read.
  - LINES: rows 1..FRAME_HEIGHT-1. Read and write.
- Transitions:
  - IDLE -> FIRST on an accepted sof pixel, which is processed as col 0.
  - FIRST -> LINES after col LINE_WIDTH-1 is accepted.
  - LINES -> IDLE after col LINE_WIDTH-1 of row FRAME_HEIGHT-1 is accepted.
- Counters: col increments per accepted pixel and wraps from LINE_WIDTH-1 to 0, incrementing row. Counters hold when in_valid is low. Gaps of any length are allowed.
- RAM drive (combinational from in_valid, in_data and the registered col):
  - mem_waddr = mem_raddr = col.
  - mem_wdata = in_data.
  - mem_wr_en = accepted pixel.
  - mem_rd_en = accepted pixel in LINES.
- Same-address read and write in one cycle returns the old (previous-row) value. The block relies on this read-before-write behaviour.
- Output latency is exactly 1 cycle. Pixel accepted in cycle T appears at T+1 with out_valid=1, out_cur=in_data, and out_above=mem_rdata. out_col, out_row, out_eol and out_eof are registered from T.
- out_valid deasserts when no pixel was accepted in the previous cycle. The other outputs then hold their last value.
- out_above_valid = 0 for row 0, 1 otherwise.
- Sync error: in_sof with in_valid in FIRST or LINES, at any position other than the expected next col 0/row 0, pulses sync_err at T+1. The frame restarts with that pixel as row 0, col 0 in FIRST; the partial frame is abandoned.
- sof with in_valid in IDLE is the normal start and raises no error. A sof arriving on the cycle directly after an eof pixel is also normal.
- Reset mid-frame aborts immediately to IDLE. RAM contents are not cleared; row 0 of the next frame overwrites them before they are used.

Optional Feature:
LBC_BORDER_REPLICATE_EN
- Defined: on row 0, out_above = out_cur (top-border replication), so 3x3/2-row kernels need no special first-row path. out_above_valid is still 0 on row 0.
- Undefined: on row 0, out_above = 0.

Test Plan:
- Small frame: LINE_WIDTH=4, FRAME_HEIGHT=3, pixel=16*row+col, continuous valid from sof.
  - Row 0 col 2 -> out_cur=0x02, out_above=0x00, out_above_valid=0.
  - Row 2 col 3 -> out_cur=0x23, out_above=0x13, out_eol=1, out_eof=1.
  - State returns to IDLE.
- Same frame with in_valid toggling every other cycle -> identical output sequence, one output per accepted pixel; mem_wr_en never high without in_valid.
- Valid pixels before any sof -> no mem_wr_en, no out_valid. The first sof pixel yields out_row=0, out_col=0 one cycle later.
- sof at row 1 col 2 -> sync_err=1 for exactly one cycle. That pixel emerges with out_row=0, out_col=0, out_above_valid=0.
- rst_n low mid-row 1, then a new frame -> all outputs 0 during reset. The new frame's row 1 out_above equals the new frame's row 0 values, not stale data.
- With LBC_BORDER_REPLICATE_EN: row 0 col 1 -> out_above=0x01. Without it -> 0x00.
